// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, LFSR seed/taps and the shift function reused by the MISR.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] TAP_MASK = 16'h002D;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & TAP_MASK), l[15:1]};
  endfunction
endpackage

// File: rtl/bist_misr16.sv
// bist_misr16: 16-bit multiple-input signature register built on the shared LFSR step.
module bist_misr16
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= lfsr_next(q) ^ din;
endmodule

// File: rtl/bist_pattern_sequencer.sv
// bist_pattern_sequencer: LFSR stimulus, settle wait, MISR compaction and golden compare for one CUT.
module bist_pattern_sequencer
  import bist_pkg::*;
#(
  parameter int N_IN = 6,
  parameter int N_OUT = 7,
  parameter int N_PATTERNS = 64,
  parameter int SEQ_DEPTH = 2,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);
  state_t state;
  logic [15:0] lfsr, lfsr_step, count, din;
  logic [3:0] settle;
  logic go, cap;
  assign din = 16'(cut_out);
  assign lfsr_step = lfsr_next(lfsr);
  assign go = start && (state == IDLE || state == DONE);
  // abort during CAPTURE must leave the partial signature untouched
  assign cap = state == CAPTURE && !abort;
  bist_misr16 u_misr (.clk(clk), .rst(rst), .clr(go), .en(cap), .din(din), .q(signature));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      count <= '0;
      settle <= '0;
      cut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == IDLE || state == DONE) begin
      lfsr <= LFSR_SEED;
      count <= '0;
      settle <= '0;
      if (start) begin
        state <= APPLY;
        cut_in <= LFSR_SEED[N_IN-1:0];
        busy <= 1'b1;
        done <= 1'b0;
        pass <= 1'b0;
      end
    end else if (abort) begin
      state <= IDLE;
      cut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == APPLY) begin
      if (settle == 4'(SEQ_DEPTH)) state <= CAPTURE;
      else settle <= settle + 4'd1;
    end else begin
      lfsr <= lfsr_step;
      count <= count + 16'd1;
      settle <= '0;
      if (count == 16'(N_PATTERNS - 1)) begin
        state <= DONE;
        cut_in <= '0;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (lfsr_next(signature) ^ din) == GOLDEN;
      end else begin
        state <= APPLY;
        cut_in <= lfsr_step[N_IN-1:0];
      end
    end
  end
endmodule

// File: tb/tb_bist_pattern_sequencer.sv
// tb_bist_pattern_sequencer: directed table plus multi-cycle sequences against an independent MISR/LFSR model.
module tb_bist_pattern_sequencer;
  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] d);
    return {s[0] ^ s[2] ^ s[3] ^ s[5] ^ d[15], s[15:1] ^ d[14:0]};
  endfunction
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] l, m;
    l = 16'hACE1;
    m = 16'h0000;
    for (int k = 0; k < n; k++) begin
      m = mstep(m, {10'b0, l[5:0]});
      l = mstep(l, 16'h0000);
    end
    return m;
  endfunction
  localparam logic [15:0] MODEL_SIG = model_sig(64);
  typedef struct {
    logic start;
    logic [5:0] ci0;
    logic b0, d0;
    logic [15:0] s0;
    logic ci2, b2, d2, p2;
    logic [15:0] s2;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [5:0] ci0, ci1;
  logic [0:0] ci2;
  logic [6:0] co0, co1, co2;
  logic b0, d0, p0, b1, d1, p1, b2, d2, p2;
  logic [15:0] s0, s1, s2, saved;
  int total = 0, bad = 0, cyc = 0;
  vec_t tbl[6];
  assign co0 = {1'b0, ci0};
  assign co1 = {1'b0, ci1};
  assign co2 = 7'h5A;
  always #5 clk = ~clk;
  bist_pattern_sequencer #(.GOLDEN(MODEL_SIG)) u0 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .cut_in(ci0), .cut_out(co0), .busy(b0), .done(d0), .pass(p0), .signature(s0));
  bist_pattern_sequencer #(.GOLDEN(MODEL_SIG ^ 16'h0001)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .cut_in(ci1), .cut_out(co1), .busy(b1), .done(d1), .pass(p1), .signature(s1));
  bist_pattern_sequencer #(.N_IN(1), .N_PATTERNS(1), .SEQ_DEPTH(0), .GOLDEN(16'h005A)) u2 (.clk(clk), .rst(rst),
    .start(start), .abort(abort), .cut_in(ci2), .cut_out(co2), .busy(b2), .done(d2), .pass(p2), .signature(s2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_start;
    start = 1;
    cyc = 0;
    tick;
    start = 0;
  endtask
  task automatic run_to_done(input bit poke);
    while (!d0 && cyc < 400) begin
      start = poke && (cyc == 50 || cyc == 150);
      tick;
    end
    start = 0;
    chk("done_cycle", cyc, 257);
  endtask
  initial begin
    tbl[0] = '{1'b1, 6'h21, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 6'h21, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 6'h21, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h005A};
    tbl[3] = '{1'b0, 6'h21, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h005A};
    tbl[4] = '{1'b0, 6'h30, 1'b1, 1'b0, 16'h0021, 1'b0, 1'b0, 1'b1, 1'b1, 16'h005A};
    tbl[5] = '{1'b0, 6'h30, 1'b1, 1'b0, 16'h0021, 1'b0, 1'b0, 1'b1, 1'b1, 16'h005A};
    tick;
    tick;
    chk("rst_cut_in", ci0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_pass", p0, 0);
    chk("rst_sig", s0, 0);
    rst = 0;
    tick;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].start;
      if (i == 0) cyc = 0;
      tick;
      chk("tbl_cut_in", ci0, tbl[i].ci0);
      chk("tbl_busy", b0, tbl[i].b0);
      chk("tbl_done", d0, tbl[i].d0);
      chk("tbl_sig", s0, tbl[i].s0);
      chk("bnd_cut_in", ci2, tbl[i].ci2);
      chk("bnd_busy", b2, tbl[i].b2);
      chk("bnd_done", d2, tbl[i].d2);
      chk("bnd_pass", p2, tbl[i].p2);
      chk("bnd_sig", s2, tbl[i].s2);
    end
    start = 0;
    run_to_done(1'b1);
    chk("loop_sig", s0, MODEL_SIG);
    chk("loop_pass", p0, 1);
    chk("loop_busy", b0, 0);
    chk("loop_cut_in", ci0, 0);
    chk("bad_golden_done", d1, 1);
    chk("bad_golden_sig", s1, MODEL_SIG);
    chk("bad_golden_pass", p1, 0);
    tick;
    chk("done_hold_sig", s0, MODEL_SIG);
    run_start;
    chk("restart_done_clr", d0, 0);
    chk("restart_pass_clr", p0, 0);
    chk("restart_busy", b0, 1);
    chk("restart_cut_in", ci0, 6'h21);
    chk("restart_sig_clr", s0, 0);
    run_to_done(1'b0);
    chk("restart_sig", s0, MODEL_SIG);
    run_start;
    while (cyc < 100) tick;
    saved = s0;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_busy", b0, 0);
    chk("abort_done", d0, 0);
    chk("abort_cut_in", ci0, 0);
    chk("abort_sig", s0, saved);
    tick;
    chk("abort_idle_busy", b0, 0);
    run_start;
    while (cyc < 5) tick;
    chk("pre_rst_sig", s0, 16'h0021);
    rst = 1;
    start = 1;
    tick;
    rst = 0;
    start = 0;
    chk("mid_rst_cut_in", ci0, 0);
    chk("mid_rst_busy", b0, 0);
    chk("mid_rst_done", d0, 0);
    chk("mid_rst_pass", p0, 0);
    chk("mid_rst_sig", s0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bist_pattern_sequencer.md
# bist_pattern_sequencer

Built-in self-test sequencer for the gate-level circuits under test (CUTs) in the netlist suite. It does four things:
- generates pseudo-random input vectors with a 16-bit LFSR and drives them onto the CUT inputs;
- waits a configurable number of cycles so registered (`fflopd`-based) paths settle;
- compacts the CUT outputs into a 16-bit MISR;
- compares the final signature against a golden value.

It sits beside one CUT instance and is the only driver of that CUT's primary inputs during test.

## Interface
- `N_IN`, 6: CUT input width, 1..16.
- `N_OUT`, 7: CUT output width, 1..16.
- `N_PATTERNS`, 64: vectors per run, 1..65535.
- `SEQ_DEPTH`, 2: extra settle cycles per vector, 0..15; matches the CUT's register depth.
- `GOLDEN`, 16'h0000: expected final signature.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `abort`  in  1  cancel a run; sampled in APPLY or CAPTURE.
- `cut_in`  out  N_IN  registered vector to the CUT.
- `cut_out`  in  N_OUT  CUT response.
- `busy`  out  1  high in APPLY or CAPTURE.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done` is high: `signature == GOLDEN`.
- `signature`  out  16  current MISR contents.

## Operation
- **States:** IDLE, APPLY, CAPTURE, DONE.
- **Reset** (`rst` high at an edge, any state) gives:
  - state IDLE;
  - `cut_in`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0;
  - LFSR=16'hACE1, pattern count=0, settle count=0.
- **IDLE:**
  - `start` → APPLY.
  - Also loads LFSR=16'hACE1, MISR=0, count=0, settle=0.
- **APPLY:**
  - `cut_in` = LFSR[N_IN-1:0].
  - Lasts SEQ_DEPTH+1 cycles (settle counts 0..SEQ_DEPTH), then → CAPTURE.
- **CAPTURE** (1 cycle):
  - MISR ← {MISR[0]^MISR[2]^MISR[3]^MISR[5]^in[15], MISR[15:1]^in[14:0]}, where `in` is `cut_out` zero-extended to 16 bits.
  - LFSR steps.
  - count++, settle=0.
  - If count was N_PATTERNS-1 → DONE, else → APPLY.
- **LFSR:**
  - Fibonacci polynomial x^16+x^14+x^13+x^11+1.
  - next = {l[0]^l[2]^l[3]^l[5], l[15:1]}.
- **DONE:**
  - `cut_in`=0; `done`=1; `pass` registered from the final MISR.
  - `start` restarts the run exactly as from IDLE and clears `done`/`pass` on the same edge.
- **abort** in APPLY or CAPTURE → IDLE:
  - `cut_in`=0, `done`=0, `pass`=0.
  - `signature` holds its partial value.
  - abort has priority over the CAPTURE→DONE transition.
- `start` during APPLY or CAPTURE is ignored.
- `cut_in` is 0 in IDLE and DONE.

## Timing
- Priority at each edge: `start` sampled at edge 0 → `busy`=1 from cycle 1.
- Pattern k is on `cut_in` during cycles 1+k(SEQ_DEPTH+2) .. k(SEQ_DEPTH+2)+SEQ_DEPTH+1.
- `cut_out` is sampled in the CAPTURE cycle (k+1)(SEQ_DEPTH+2), with a 0-cycle combinational CUT assumed beyond SEQ_DEPTH.
- `done` rises at cycle 1+N_PATTERNS(SEQ_DEPTH+2); with defaults, cycle 257.
- `signature` updates the cycle after each CAPTURE and is stable throughout DONE.
- When `rst` and `start` are both high at the same edge, `rst` wins.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum;
  - LFSR seed 16'hACE1;
  - the tap mask;
  - an `lfsr_next` function, reused by the MISR.
- One sub-module, `bist_misr16`: `clk`, `rst`, `clr`, `en`, `din[15:0]`, `q[15:0]`.
- The LFSR and FSM stay in the top module.

## Test plan
- **Reset and first vectors:** defaults, `start` pulse.
  - `cut_in`=6'h21 for cycles 1–3.
  - CAPTURE at cycle 4.
  - `cut_in`=6'h30 (LFSR 16'h5670) from cycle 5.
- **Loopback run:** `cut_out`={1'b0,`cut_in`}.
  - `done` rises at cycle 257.
  - `signature` matches the bench reference model.
  - With GOLDEN set to the model value, `pass`=1; with GOLDEN=model^1, `pass`=0.
- **Boundary run:** N_PATTERNS=1, SEQ_DEPTH=0.
  - APPLY at cycle 1, CAPTURE at cycle 2, `done` at cycle 3.
  - `signature` = `cut_out` zero-extended.
- **Abort:** `abort` at cycle 100 of a default run.
  - IDLE at cycle 101 with `busy`=0, `done`=0, `cut_in`=0.
  - `signature` unchanged from cycle 100.
- **Start while busy:** extra `start` pulses during the run have no effect; `done` still at cycle 257.
- **Reset and restart:**
  - `rst` mid-APPLY: all outputs 0 the next cycle.
  - A `start` in DONE reruns and reproduces an identical signature.
